// File: rtl/rr_grant_ctrl8.sv
// Eight-way round-robin arbiter holding each grant until the winner releases.
// RR_GRANT_TIMEOUT_EN adds a MAX_HOLD-cycle forced release with a tmo pulse.
module rr_grant_ctrl8 #(
   parameter int unsigned MAX_HOLD = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [7:0] req,
   output logic [7:0] gnt,
   output logic [2:0] gnt_id,
   output logic       gnt_vld,
   output logic       tmo
);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_e;

   if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_hold
      $error("rr_grant_ctrl8: MAX_HOLD must be 2..255");
   end

   state_e     state_q, state_d;
   logic [2:0] ptr_q, ptr_d;
   logic [7:0] gnt_q, gnt_d;
   logic [2:0] gnt_id_q, gnt_id_d;
   logic       gnt_vld_q, gnt_vld_d;

   logic       win_vld;
   logic [2:0] win_id;
   logic       force_rel;

   // Descending scan so the candidate closest to ptr is written last.
   always_comb begin
      win_vld = 1'b0;
      win_id  = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (req[ptr_q + 3'(i)]) begin
            win_vld = 1'b1;
            win_id  = ptr_q + 3'(i);
         end
      end
   end

`ifdef RR_GRANT_TIMEOUT_EN
   logic [7:0] hold_q, hold_d;
   logic       tmo_q, tmo_d;

   assign force_rel = (state_q == GRANT) && req[gnt_id_q]
                      && (hold_q == 8'(MAX_HOLD - 1));

   always_comb begin
      hold_d = 8'd0;
      tmo_d  = force_rel;
      if (state_q == GRANT && !force_rel) begin
         hold_d = hold_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_q <= 8'd0;
         tmo_q  <= 1'b0;
      end else begin
         hold_q <= hold_d;
         tmo_q  <= tmo_d;
      end
   end

   assign tmo = tmo_q;
`else
   assign force_rel = 1'b0;
   assign tmo       = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      gnt_d     = gnt_q;
      gnt_id_d  = gnt_id_q;
      gnt_vld_d = gnt_vld_q;
      unique case (state_q)
         IDLE: begin
            if (en && win_vld) begin
               state_d   = GRANT;
               gnt_id_d  = win_id;
               gnt_d     = 8'b1 << win_id;
               gnt_vld_d = 1'b1;
            end
         end
         GRANT: begin
            if (!req[gnt_id_q] || force_rel) begin
               state_d   = IDLE;
               gnt_d     = 8'h00;
               gnt_vld_d = 1'b0;
               ptr_d     = gnt_id_q + 3'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         ptr_q     <= 3'd0;
         gnt_q     <= 8'h00;
         gnt_id_q  <= 3'd0;
         gnt_vld_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         gnt_q     <= gnt_d;
         gnt_id_q  <= gnt_id_d;
         gnt_vld_q <= gnt_vld_d;
      end
   end

   assign gnt     = gnt_q;
   assign gnt_id  = gnt_id_q;
   assign gnt_vld = gnt_vld_q;

endmodule

// File: tb/tb_rr_grant_ctrl8.sv
// Directed bench for rr_grant_ctrl8 with hand-computed expectations.
// Define RR_GRANT_TIMEOUT_EN to exercise the forced release at MAX_HOLD=4.
module tb_rr_grant_ctrl8;

`ifdef RR_GRANT_TIMEOUT_EN
   localparam int HOLD = 4;
`else
   localparam int HOLD = 16;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b1;
   logic [7:0] req = 8'h00;
   logic [7:0] gnt;
   logic [2:0] gnt_id;
   logic       gnt_vld;
   logic       tmo;

   int n_run  = 0;
   int n_fail = 0;

   rr_grant_ctrl8 #(.MAX_HOLD(HOLD)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .req     (req),
      .gnt     (gnt),
      .gnt_id  (gnt_id),
      .gnt_vld (gnt_vld),
      .tmo     (tmo)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
      n_run++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [7:0] eg,
                          input logic [2:0] eid, input logic ev,
                          input logic et);
      chk({tag, ".gnt"}, gnt, eg);
      chk({tag, ".id"}, 8'(gnt_id), 8'(eid));
      chk({tag, ".vld"}, 8'(gnt_vld), 8'(ev));
      chk({tag, ".tmo"}, 8'(tmo), 8'(et));
   endtask

   initial begin
      logic [7:0] exp_g;
      // reset state
      step();
      step();
      chk_all("rst", 8'h00, 3'd0, 1'b0, 1'b0);
      rst_n = 1'b1;

      // first grant after reset, then async reset mid-grant
      req = 8'h01;
      step();
      chk_all("first", 8'h01, 3'd0, 1'b1, 1'b0);
      #2 rst_n = 1'b0;
      #1 chk_all("async_rst", 8'h00, 3'd0, 1'b0, 1'b0);
      req = 8'h00;
      step();
      rst_n = 1'b1;

      // single request held four cycles (ptr=0)
      req = 8'h08;
      step();
      chk_all("single0", 8'h08, 3'd3, 1'b1, 1'b0);
      for (int i = 1; i < 4; i++) begin
         step();
         chk("single_hold", gnt, 8'h08);
      end
      req = 8'h00;
      step();
      chk_all("single_rel", 8'h00, 3'd3, 1'b0, 1'b0);

      // fairness sweep from ptr=0
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      req = 8'hFF;
      for (int k = 0; k < 9; k++) begin
         exp_g = 8'h01 << (k % 8);
         step();
         chk_all("fair_gnt", exp_g, 3'(k % 8), 1'b1, 1'b0);
         step();
         chk("fair_hold", gnt, exp_g);
         req = 8'hFF & ~exp_g;
         step();
         chk_all("fair_idle", 8'h00, 3'(k % 8), 1'b0, 1'b0);
         req = 8'hFF;
      end
      req = 8'h00;
      step();

      // wrap-around: grant 5 then ptr=6 must pick 0 over 5
      req = 8'h20;
      step();
      chk("wrap_g5", gnt, 8'h20);
      req = 8'h00;
      step();
      req = 8'h21;
      step();
      chk_all("wrap", 8'h01, 3'd0, 1'b1, 1'b0);
      req = 8'h00;
      step();

      // enable gating (ptr=1)
      en = 1'b0;
      req = 8'h10;
      step();
      chk("en_off0", gnt, 8'h00);
      step();
      chk("en_off1", gnt, 8'h00);
      en = 1'b1;
      step();
      chk_all("en_on", 8'h10, 3'd4, 1'b1, 1'b0);
      en = 1'b0;
      step();
      chk("en_drop0", gnt, 8'h10);
      step();
      chk("en_drop1", gnt, 8'h10);
      req = 8'h00;
      step();
      chk("en_rel", gnt, 8'h00);
      en = 1'b1;

      // other lines ignored during grant (ptr=5)
      req = 8'h02;
      step();
      chk("other_g", gnt, 8'h02);
      req = 8'h83;
      step();
      chk("other_hold", gnt, 8'h02);
      req = 8'h81;
      step();
      chk("other_rel", gnt, 8'h00);
      step();
      chk_all("other_next", 8'h80, 3'd7, 1'b1, 1'b0);
      req = 8'h00;
      step();

      // released requester re-asserting loses (ptr=0)
      req = 8'h03;
      step();
      chk("reasrt_g0", gnt, 8'h01);
      req = 8'h02;
      step();
      chk("reasrt_idle", gnt, 8'h00);
      req = 8'h03;
      step();
      chk("reasrt_g1", gnt, 8'h02);
      req = 8'h00;
      step();

      // hold limit (ptr=2)
      req = 8'h24;
      step();
      chk_all("tmo_g", 8'h04, 3'd2, 1'b1, 1'b0);
`ifdef RR_GRANT_TIMEOUT_EN
      for (int i = 1; i < 4; i++) begin
         step();
         chk("tmo_hold", gnt, 8'h04);
         chk("tmo_low", 8'(tmo), 8'h00);
      end
      step();
      chk_all("tmo_force", 8'h00, 3'd2, 1'b0, 1'b1);
      step();
      chk_all("tmo_next", 8'h20, 3'd5, 1'b1, 1'b0);
`else
      for (int i = 1; i < 24; i++) begin
         step();
         chk("nolimit_hold", gnt, 8'h04);
         chk("nolimit_tmo", 8'(tmo), 8'h00);
      end
`endif
      req = 8'h00;
      step();
      chk_all("end_idle", 8'h00, gnt_id, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
